// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: the sequencer state
// encoding, the instruction word width and the default reset PC.
// ---------------------------------------------------------------------------
package fetch_pkg;

    // Sequencer states: BOOT spends one edge after reset before any fetch,
    // RUN fetches and handles redirects, FAULT is sticky until reset.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Owns the program counter, presents it as the byte address of a
// combinational instruction memory, and registers each fetched word into an
// IF/ID stage handed to decode with a valid/ready handshake. Redirects from
// execute reload the PC and squash the held word; an illegal fetch address
// (misaligned or beyond the memory depth) parks the unit in a sticky fault.
//
// Ports:
//   i_clk              clock, rising edge
//   i_rst              asynchronous active-high reset
//   o_imemAddress      byte address to instruction memory (the PC)
//   i_imemInstruction  combinational read data for o_imemAddress
//   i_redirectValid    one-cycle redirect request from execute
//   i_redirectTarget   byte target of the redirect
//   o_outValid         IF/ID register holds a valid instruction
//   i_outReady         decode accepts when o_outValid & i_outReady
//   o_outInstruction   registered instruction word
//   o_outPC            byte address of o_outInstruction
//   o_outPCPlus4       o_outPC + 4
//   o_fetchFault       sticky illegal-fetch flag
//   o_fetchCount       instructions accepted by decode (wraps)
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = 128
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic [31:0]        o_imemAddress,
    input  logic [INSTR_W-1:0] i_imemInstruction,
    input  logic               i_redirectValid,
    input  logic [31:0]        i_redirectTarget,
    output logic               o_outValid,
    input  logic               i_outReady,
    output logic [INSTR_W-1:0] o_outInstruction,
    output logic [31:0]        o_outPC,
    output logic [31:0]        o_outPCPlus4,
    output logic               o_fetchFault,
    output logic [31:0]        o_fetchCount
);

    // Range checks compare word indices, so an address that wrapped past
    // 2^32 still lands outside the memory and is reported as a fault.
    localparam logic [29:0] WORD_LIMIT = 30'(IMEM_WORDS);

    fetch_state_e       r_state;
    fetch_state_e       w_nextState;
    logic [31:0]        r_pc;
    logic               r_outValid;
    logic [INSTR_W-1:0] r_outInstruction;
    logic [31:0]        r_outPC;
    logic [31:0]        r_outPCPlus4;
    logic [31:0]        r_fetchCount;

    logic               w_load;
    logic               w_pcOutOfRange;
    logic               w_targetIllegal;
    logic               w_doFetch;
    logic               w_doRedirect;
    logic               w_squash;

    assign w_load          = !r_outValid || i_outReady;
    assign w_pcOutOfRange  = (r_pc[31:2] >= WORD_LIMIT);
    assign w_targetIllegal = (i_redirectTarget[1:0] != 2'b00) ||
                             (i_redirectTarget[31:2] >= WORD_LIMIT);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and datapath control. In RUN a redirect outranks the
    // out-of-range check, which outranks an ordinary fetch; with none of
    // them active the stage simply stalls.
    always_comb begin
        w_nextState  = r_state;
        w_doFetch    = 1'b0;
        w_doRedirect = 1'b0;
        w_squash     = 1'b0;
        case (r_state)
            BOOT: begin
                w_nextState = RUN;
            end
            RUN: begin
                if (i_redirectValid) begin
                    w_squash = 1'b1;
                    if (w_targetIllegal) begin
                        w_nextState = FAULT;
                    end else begin
                        w_doRedirect = 1'b1;
                    end
                end else if (w_load && w_pcOutOfRange) begin
                    w_squash    = 1'b1;
                    w_nextState = FAULT;
                end else if (w_load) begin
                    w_doFetch = 1'b1;
                end
            end
            FAULT: begin
                w_squash = 1'b1;
            end
            default: begin
                w_nextState = BOOT;
            end
        endcase
    end

    // PC, IF/ID stage and accepted-instruction counter. The counter looks
    // only at the handshake, so a word taken by decode on the same edge as
    // a squashing redirect is still counted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc             <= RESET_PC;
            r_outValid       <= 1'b0;
            r_outInstruction <= '0;
            r_outPC          <= '0;
            r_outPCPlus4     <= '0;
            r_fetchCount     <= '0;
        end else begin
            if (r_outValid && i_outReady) begin
                r_fetchCount <= r_fetchCount + 32'd1;
            end
            if (w_doRedirect) begin
                r_pc <= i_redirectTarget;
            end else if (w_doFetch) begin
                r_pc             <= r_pc + 32'd4;
                r_outInstruction <= i_imemInstruction;
                r_outPC          <= r_pc;
                r_outPCPlus4     <= r_pc + 32'd4;
            end
            if (w_doFetch) begin
                r_outValid <= 1'b1;
            end else if (w_squash) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign o_imemAddress    = r_pc;
    assign o_outValid       = r_outValid;
    assign o_outInstruction = r_outInstruction;
    assign o_outPC          = r_outPC;
    assign o_outPCPlus4     = r_outPCPlus4;
    assign o_fetchFault     = (r_state == FAULT);
    assign o_fetchCount     = r_fetchCount;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. The stimulus process pushes the
// byte addresses it expects decode to accept into a scoreboard queue; a
// monitor pops one entry per handshake and checks PC, PC+4 and the word the
// bench's own instruction memory holds at that address. Cycle-specific
// behaviour (boot timing, stall hold, squash bubble, faults, async reset) is
// checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imemAddress;
    logic [31:0] imemInstruction;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstruction;
    logic [31:0] outPC;
    logic [31:0] outPCPlus4;
    logic        fetchFault;
    logic [31:0] fetchCount;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [31:0] expectQ[$];

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(128)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imemAddress    (imemAddress),
        .i_imemInstruction(imemInstruction),
        .i_redirectValid  (redirectValid),
        .i_redirectTarget (redirectTarget),
        .o_outValid       (outValid),
        .i_outReady       (outReady),
        .o_outInstruction (outInstruction),
        .o_outPC          (outPC),
        .o_outPCPlus4     (outPCPlus4),
        .o_fetchFault     (fetchFault),
        .o_fetchCount     (fetchCount)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: each word tags its own byte address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'hA500_0000 + addr;
    endfunction

    // Combinational instruction memory beside the fetch unit.
    assign imemInstruction = memWord(imemAddress);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir,
                                 input logic [31:0] target);
        outReady       = ready;
        redirectValid  = redir;
        redirectTarget = target;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release between edges, then follow the BOOT edge and the first
    // fetch edge. Returns 1 time unit after the first fetch edge.
    task automatic resetDut(input logic readyAfter);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        expectQ.delete();
        repeat (2) @(posedge clk);
        #3;
        outReady = readyAfter;
        rst      = 1'b0;
        tick();
        checkOutput("boot_valid_low", {31'b0, outValid}, 32'd0);
        tick();
        checkOutput("first_valid", {31'b0, outValid}, 32'd1);
        checkOutput("first_pc", outPC, 32'h0);
    endtask

    task automatic pushRange(input logic [31:0] first, input logic [31:0] last);
        for (logic [31:0] a = first; a <= last; a += 32'd4) begin
            expectQ.push_back(a);
        end
    endtask

    task automatic waitForPC(input logic [31:0] pc, input int budget);
        int  n   = 0;
        logic hit = 1'b0;
        while (!hit && n < budget) begin
            if (outValid && outPC == pc) begin
                hit = 1'b1;
            end else begin
                tick();
                n++;
            end
        end
        checkOutput("reach_pc", hit ? pc : outPC, pc);
    endtask

    // Wait until every expected word has been accepted, then cross the edge
    // on which the last handshake completes.
    task automatic waitDrain(input int budget);
        int n = 0;
        while (expectQ.size() > 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("drain_left", 32'(expectQ.size()), 32'd0);
        expectQ.delete();
        tick();
    endtask

    // Monitor: a handshake completes at the next rising edge whenever valid
    // and ready are both high mid-cycle.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (!rst && outValid && outReady) begin
                if (expectQ.size() == 0) begin
                    checkOutput("unexpected_accept", outPC, 32'hFFFF_FFFF);
                end else begin
                    exp = expectQ.pop_front();
                    checkOutput("sb_pc", outPC, exp);
                    checkOutput("sb_pc_plus4", outPCPlus4, exp + 32'd4);
                    checkOutput("sb_instr", outInstruction, memWord(exp));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        #1;
        $display("[TB] reset values");
        checkOutput("rst_imem_addr", imemAddress, 32'h0);
        checkOutput("rst_valid", {31'b0, outValid}, 32'd0);
        checkOutput("rst_instr", outInstruction, 32'h0);
        checkOutput("rst_pc", outPC, 32'h0);
        checkOutput("rst_pc_plus4", outPCPlus4, 32'h0);
        checkOutput("rst_fault", {31'b0, fetchFault}, 32'd0);
        checkOutput("rst_count", fetchCount, 32'd0);

        $display("[TB] straight-line fetch");
        resetDut(1'b1);
        pushRange(32'h0, 32'h24);
        waitDrain(50);
        outReady = 1'b0;
        checkOutput("straight_count", fetchCount, 32'd10);

        $display("[TB] stall");
        resetDut(1'b1);
        pushRange(32'h0, 32'h4);
        waitForPC(32'h8, 20);
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_valid", {31'b0, outValid}, 32'd1);
            checkOutput("stall_pc", outPC, 32'h8);
            checkOutput("stall_instr", outInstruction, memWord(32'h8));
            checkOutput("stall_fetch_pc", imemAddress, 32'hC);
        end
        pushRange(32'h8, 32'h14);
        outReady = 1'b1;
        waitDrain(20);
        outReady = 1'b0;
        checkOutput("stall_count", fetchCount, 32'd6);

        $display("[TB] redirect");
        resetDut(1'b1);
        pushRange(32'h0, 32'hC);
        waitForPC(32'h10, 20);
        applyStimulus(1'b0, 1'b1, 32'h4);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("redir_bubble", {31'b0, outValid}, 32'd0);
        checkOutput("redir_fetch_pc", imemAddress, 32'h4);
        pushRange(32'h4, 32'hC);
        tick();
        checkOutput("redir_valid", {31'b0, outValid}, 32'd1);
        checkOutput("redir_pc", outPC, 32'h4);
        checkOutput("redir_pc_plus4", outPCPlus4, 32'h8);
        waitDrain(20);
        outReady = 1'b0;
        checkOutput("redir_count", fetchCount, 32'd7);

        $display("[TB] redirect concurrent with accept");
        resetDut(1'b1);
        pushRange(32'h0, 32'h10);
        waitForPC(32'h10, 20);
        applyStimulus(1'b1, 1'b1, 32'h20);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("conc_bubble", {31'b0, outValid}, 32'd0);
        checkOutput("conc_count", fetchCount, 32'd5);
        pushRange(32'h20, 32'h24);
        tick();
        checkOutput("conc_pc", outPC, 32'h20);
        waitDrain(20);
        outReady = 1'b0;
        checkOutput("conc_count_end", fetchCount, 32'd7);

        $display("[TB] misaligned redirect");
        resetDut(1'b0);
        applyStimulus(1'b0, 1'b1, 32'h6);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("mis_fault", {31'b0, fetchFault}, 32'd1);
        checkOutput("mis_valid", {31'b0, outValid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        repeat (2) tick();
        checkOutput("mis_fault_sticky", {31'b0, fetchFault}, 32'd1);
        checkOutput("mis_valid_sticky", {31'b0, outValid}, 32'd0);
        checkOutput("mis_pc_frozen", imemAddress, 32'h4);
        checkOutput("mis_count", fetchCount, 32'd0);
        outReady = 1'b0;

        $display("[TB] redirect to last word, then past the end");
        resetDut(1'b0);
        applyStimulus(1'b0, 1'b1, 32'h1FC);
        tick();
        checkOutput("edge_fault_low", {31'b0, fetchFault}, 32'd0);
        checkOutput("edge_fetch_pc", imemAddress, 32'h1FC);
        applyStimulus(1'b0, 1'b1, 32'h200);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("range_fault", {31'b0, fetchFault}, 32'd1);
        checkOutput("range_valid", {31'b0, outValid}, 32'd0);

        $display("[TB] sequential run off the end of memory");
        resetDut(1'b1);
        pushRange(32'h0, 32'h1FC);
        waitDrain(400);
        outReady = 1'b0;
        checkOutput("seq_fault", {31'b0, fetchFault}, 32'd1);
        checkOutput("seq_valid", {31'b0, outValid}, 32'd0);
        checkOutput("seq_count", fetchCount, 32'd128);
        checkOutput("seq_fetch_pc", imemAddress, 32'h200);

        $display("[TB] async reset mid-run");
        resetDut(1'b1);
        pushRange(32'h0, 32'h4);
        waitForPC(32'h8, 20);
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", {31'b0, outValid}, 32'd0);
        checkOutput("arst_pc", outPC, 32'h0);
        checkOutput("arst_instr", outInstruction, 32'h0);
        checkOutput("arst_count", fetchCount, 32'd0);
        checkOutput("arst_fetch_pc", imemAddress, 32'h0);
        resetDut(1'b1);
        pushRange(32'h0, 32'h4);
        waitDrain(20);
        outReady = 1'b0;
        checkOutput("arst_fault", {31'b0, fetchFault}, 32'd0);
        checkOutput("arst_count_end", fetchCount, 32'd2);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequencer for the instruction memory: owns the program counter, drives the word address into the combinational instruction memory, and registers each fetched word into an IF/ID output stage with a valid/ready handshake. It sits between the instruction memory and the decode stage. It also absorbs branch/jump redirects from execute and raises a sticky fault on an illegal fetch address.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 128: instruction memory depth in words; legal word index 0..IMEM_WORDS-1.
- Clk  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Imem_Address  output  32  byte address to instruction memory; equals PC.
- Imem_Instruction  input  32  combinational read data for Imem_Address.
- Redirect_Valid  input  1  redirect request from execute; one-cycle pulse.
- Redirect_Target  input  32  byte target of redirect.
- Out_Valid  output  1  IF/ID register holds a valid instruction.
- Out_Ready  input  1  decode accepts when Out_Valid & Out_Ready.
- Out_Instruction  output  32  registered instruction word.
- Out_PC  output  32  byte address of Out_Instruction.
- Out_PCPlus4  output  32  Out_PC + 4.
- Fetch_Fault  output  1  sticky illegal-fetch flag.
- Fetch_Count  output  32  instructions accepted by decode; wraps at 2^32.

## Operation
- States: BOOT, RUN, FAULT. Reset -> BOOT; BOOT -> RUN unconditionally on the next edge, with no fetch in BOOT.
- load = !Out_Valid | Out_Ready (stage empty or being drained).
- RUN, priority high to low:
  1. Redirect_Valid: Out_Valid<=0 (squash, even if held unconsumed). If Redirect_Target[1:0]!=0 or Redirect_Target[31:2]>=IMEM_WORDS, go to FAULT. Otherwise PC<=Redirect_Target.
  2. load and PC[31:2]>=IMEM_WORDS: go to FAULT, Out_Valid<=0.
  3. load: Out_Instruction<=Imem_Instruction, Out_PC<=PC, Out_PCPlus4<=PC+4, Out_Valid<=1, PC<=PC+4.
  4. Otherwise (stall): hold all registers.
- FAULT: Fetch_Fault=1. No fetches. Redirects ignored. Out_Valid=0. PC frozen. Only Reset exits.
- Fetch_Count increments on every Out_Valid & Out_Ready edge, including the edge on which a redirect squashes. Decode has consumed that word.
- PC+4 arithmetic is 32-bit modulo. Range is checked on word index, so wrap is caught as out of range.

## Timing
- Reset values: PC=RESET_PC, Imem_Address=RESET_PC, Out_Valid=0, Out_Instruction=0, Out_PC=0, Out_PCPlus4=0, Fetch_Fault=0, Fetch_Count=0, state=BOOT.
- First valid instruction: Out_Valid rises after the 2nd rising edge following Reset deassertion (BOOT edge, then fetch edge).
- Fetch latency is one edge from PC to Out_*. Throughput is one instruction per cycle while Out_Ready=1.
- Redirect sampled at edge k: PC=target after k, target instruction registered at edge k+1. Penalty is one bubble cycle.
- Redirect and Out_Ready in the same cycle: the handshake completes (count++), then the squash applies.
- Out_* are stable while Out_Valid & !Out_Ready (standard valid/ready hold rule).
- Reset mid-operation: all outputs go to reset values immediately (asynchronously).

## Structure
- Shared package fetch_pkg holds:
  - state enum (BOOT, RUN, FAULT)
  - INSTR_W=32
  - the default RESET_PC constant
- Single module with no sub-module. The IF/ID register and PC logic are small enough to stay inline.
- The instruction memory is instantiated alongside this block at top level, not inside it.

## Test plan
- Straight-line fetch: Reset, then Out_Ready=1 with memory words 0..9. Out_PC sequence is 0,4,...,36, with Out_Valid first high after edge 2. Fetch_Count=10 after ten accepts.
- Stall: drop Out_Ready for 3 cycles while Out_PC=8. Out_Instruction, Out_PC=8 and PC=12 are held. Resume: next Out_PC=12 with no word skipped.
- Redirect: at Out_PC=16, Redirect_Valid with target 0x4. Out_Valid is 0 for one cycle, then Out_PC=4, Out_PCPlus4=8.
- Redirect concurrent with accept: Out_Valid=Out_Ready=1 and redirect to 0x20 in the same cycle. Fetch_Count increments by 1, then Out_PC=0x20.
- Faults:
  - Redirect to 0x6 gives Fetch_Fault=1 and Out_Valid=0 permanently; a later redirect to 0x0 is ignored.
  - Redirect to 0x200 (index 128) also faults.
  - Sequential run to PC=0x200 faults after Out_PC=0x1FC is delivered.
- Async reset mid-run: assert Reset between edges while Out_Valid=1. Outputs clear immediately. After release, the sequence restarts from RESET_PC with Fetch_Fault=0.
